// File: rtl/fft_peak_unload.sv
// rtl/fft_peak_unload.sv - scans FFT result RAM bins 1..FFT_SIZE/2-1 and reports the strongest L1-magnitude bin
// Optional build macro PEAK_THRESH_EN adds a per-frame detection threshold (thresh / peak_found).
module fft_peak_unload #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int FFT_SIZE  = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fft_done,
  output logic [N-1:0]         rd_add,
  output logic                 rd_en,
  input  logic [BIT_WIDTH-1:0] rd_re,
  input  logic [BIT_WIDTH-1:0] rd_im,
  output logic [N-2:0]         peak_bin,
  output logic [BIT_WIDTH:0]   peak_mag,
  output logic                 peak_valid,
  input  logic                 peak_ready,
  output logic                 busy,
  output logic                 frame_drop
`ifdef PEAK_THRESH_EN
  ,
  input  logic [BIT_WIDTH:0]   thresh,
  output logic                 peak_found
`endif
);

  localparam int NB = N - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [N-1:0]         LAST_ADD = N'(FFT_SIZE / 2 - 1);
  localparam logic [N-1:0]         ADD_ONE  = N'(1);
  localparam logic [NB-1:0]        BIN_ONE  = NB'(1);
  localparam logic [BIT_WIDTH-1:0] ONE      = BIT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic                 fft_done_q;
  logic [N-1:0]         rd_add_q, rd_add_d;
  logic                 rd_en_q, rd_en_d;
  logic                 smp_vld_q;
  logic [NB-1:0]        smp_bin_q;
  logic [BIT_WIDTH:0]   best_mag_q, best_mag_d;
  logic [NB-1:0]        best_bin_q, best_bin_d;
  logic [BIT_WIDTH:0]   peak_mag_q, peak_mag_d;
  logic [NB-1:0]        peak_bin_q, peak_bin_d;
`ifdef PEAK_THRESH_EN
  logic [BIT_WIDTH:0]   thresh_q, thresh_d;
  logic                 found_q, found_d;
`endif

  logic                 rise;
  logic [BIT_WIDTH-1:0] re_abs, im_abs;
  logic [BIT_WIDTH:0]   mag;

  assign rise = fft_done & ~fft_done_q;

  // abs(-2^(BW-1)) wraps to 2^(BW-1), which is exactly right when read as unsigned
  assign re_abs = rd_re[BIT_WIDTH-1] ? (~rd_re + ONE) : rd_re;
  assign im_abs = rd_im[BIT_WIDTH-1] ? (~rd_im + ONE) : rd_im;
  assign mag    = {1'b0, re_abs} + {1'b0, im_abs};

  always_comb begin
    state_d    = state_q;
    rd_add_d   = rd_add_q;
    rd_en_d    = 1'b0;
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;
    peak_mag_d = peak_mag_q;
    peak_bin_d = peak_bin_q;
`ifdef PEAK_THRESH_EN
    thresh_d   = thresh_q;
    found_d    = found_q;
`endif

    // strict compare keeps the lowest bin on ties
    if (smp_vld_q && (mag > best_mag_q)) begin
      best_mag_d = mag;
      best_bin_d = smp_bin_q;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = READ;
          rd_add_d   = ADD_ONE;
          rd_en_d    = 1'b1;
          best_mag_d = '0;
          best_bin_d = BIN_ONE;
`ifdef PEAK_THRESH_EN
          thresh_d   = thresh;
`endif
        end
      end
      READ: begin
        if (rd_add_q == LAST_ADD) begin
          state_d = DRAIN;
        end else begin
          rd_add_d = rd_add_q + ADD_ONE;
          rd_en_d  = 1'b1;
        end
      end
      DRAIN: begin
        // best_*_d already includes the final sample arriving this cycle
        state_d = HOLD;
`ifdef PEAK_THRESH_EN
        if (best_mag_d > thresh_q) begin
          found_d    = 1'b1;
          peak_mag_d = best_mag_d;
          peak_bin_d = best_bin_d;
        end else begin
          found_d    = 1'b0;
          peak_mag_d = '0;
          peak_bin_d = '0;
        end
`else
        peak_mag_d = best_mag_d;
        peak_bin_d = best_bin_d;
`endif
      end
      HOLD: begin
        if (peak_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fft_done_q <= 1'b0;
      rd_add_q   <= '0;
      rd_en_q    <= 1'b0;
      smp_vld_q  <= 1'b0;
      smp_bin_q  <= '0;
      best_mag_q <= '0;
      best_bin_q <= '0;
      peak_mag_q <= '0;
      peak_bin_q <= '0;
`ifdef PEAK_THRESH_EN
      thresh_q   <= '0;
      found_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fft_done_q <= fft_done;
      rd_add_q   <= rd_add_d;
      rd_en_q    <= rd_en_d;
      smp_vld_q  <= rd_en_q;
      smp_bin_q  <= rd_add_q[NB-1:0];
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
      peak_mag_q <= peak_mag_d;
      peak_bin_q <= peak_bin_d;
`ifdef PEAK_THRESH_EN
      thresh_q   <= thresh_d;
      found_q    <= found_d;
`endif
    end
  end

  assign rd_add     = rd_add_q;
  assign rd_en      = rd_en_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_valid = (state_q == HOLD);
  assign busy       = (state_q == READ) || (state_q == DRAIN);
  assign frame_drop = rise && (state_q != IDLE);
`ifdef PEAK_THRESH_EN
  assign peak_found = found_q;
`endif

endmodule
